// File: rtl/tone_mapping_pwl.sv
// Piecewise-linear tone mapping curve shared by CH_NUM parallel channels.
// The curve is held in two knot banks: software writes the shadow bank, and
// the datapath reads the active bank. A commit request copies shadow to active
// on the next line start. Three-stage pipeline: lookup, multiply, add/clip.
module tone_mapping_pwl #(
  parameter int unsigned CIW      = 15,
  parameter int unsigned COW      = 13,
  parameter int unsigned CH_NUM   = 3,
  parameter int unsigned SEG_SFT  = 10,
  localparam int unsigned KNOT_NUM = (1 << (CIW - SEG_SFT)) + 1,
  localparam int unsigned AW       = $clog2(KNOT_NUM)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CH_NUM*CIW-1:0]   i_data,
  input  logic                    i_hstr,
  input  logic                    i_href,
  input  logic                    i_hend,
  input  logic                    i_bypass,
  input  logic                    i_lut_wr,
  input  logic [AW-1:0]           i_lut_addr,
  input  logic [COW-1:0]          i_lut_wdata,
  input  logic                    i_lut_commit,
  output logic [CH_NUM*COW-1:0]   o_data,
  output logic                    o_hstr,
  output logic                    o_href,
  output logic                    o_hend,
  output logic                    o_commit_pend
);

  localparam int unsigned DW      = COW + 1;            // signed knot difference
  localparam int unsigned PW      = DW + SEG_SFT + 1;   // signed product
  localparam int unsigned MaxKnot = (1 << COW) - 1;
  localparam logic signed [PW-1:0] RndC = PW'(1 << (SEG_SFT - 1));
  localparam logic signed [PW-1:0] MaxY = PW'(MaxKnot);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StPend = 1'b1;

  // Identity ramp used as the reset curve.
  function automatic logic [COW-1:0] ident_knot(input int unsigned k);
    int unsigned v;
    v = (k << SEG_SFT) >> (CIW - COW);
    if (v > MaxKnot) ident_knot = '1;
    else             ident_knot = v[COW-1:0];
  endfunction

  logic [0:0]     state_q, state_d;
  logic [COW-1:0] shadow_q [KNOT_NUM];
  logic [COW-1:0] shadow_d [KNOT_NUM];
  logic [COW-1:0] active_q [KNOT_NUM];
  logic [COW-1:0] active_d [KNOT_NUM];
  logic [COW-1:0] lut_view [KNOT_NUM];
  logic           swap;

  logic [COW-1:0]          s1_y0_q   [CH_NUM];
  logic [COW-1:0]          s1_y0_d   [CH_NUM];
  logic signed [DW-1:0]    s1_diff_q [CH_NUM];
  logic signed [DW-1:0]    s1_diff_d [CH_NUM];
  logic [SEG_SFT-1:0]      s1_frac_q [CH_NUM];
  logic [SEG_SFT-1:0]      s1_frac_d [CH_NUM];
  logic [COW-1:0]          s1_bx_q   [CH_NUM];
  logic [COW-1:0]          s1_bx_d   [CH_NUM];
  logic [COW-1:0]          s2_y0_q   [CH_NUM];
  logic [COW-1:0]          s2_y0_d   [CH_NUM];
  logic signed [PW-1:0]    s2_prod_q [CH_NUM];
  logic signed [PW-1:0]    s2_prod_d [CH_NUM];
  logic [COW-1:0]          s2_bx_q   [CH_NUM];
  logic [COW-1:0]          s2_bx_d   [CH_NUM];
  logic [COW-1:0]          s3_y_q    [CH_NUM];
  logic [COW-1:0]          s3_y_d    [CH_NUM];
  logic                    s1_bp_q, s2_bp_q;
  logic [2:0]              hstr_q, hstr_d, href_q, href_d, hend_q, hend_d;

  assign swap = (state_q == StPend) && i_hstr;

  // Shadow write, commit FSM and bank copy. On the swap cycle the lookup reads
  // the post-write shadow so the line-start sample already sees the new curve.
  always_comb begin
    state_d = state_q;
    for (int unsigned k = 0; k < KNOT_NUM; k++) begin
      shadow_d[k] = shadow_q[k];
      if (i_lut_wr && (i_lut_addr == AW'(k))) shadow_d[k] = i_lut_wdata;
      active_d[k] = swap ? shadow_d[k] : active_q[k];
      lut_view[k] = swap ? shadow_d[k] : active_q[k];
    end
    unique case (state_q)
      StIdle:  if (i_lut_commit) state_d = StPend;
      StPend:  if (i_hstr)       state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Knot banks and FSM state; reset restores the identity curve.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      for (int unsigned k = 0; k < KNOT_NUM; k++) begin
        shadow_q[k] <= ident_knot(k);
        active_q[k] <= ident_knot(k);
      end
    end else begin
      state_q <= state_d;
      for (int unsigned k = 0; k < KNOT_NUM; k++) begin
        shadow_q[k] <= shadow_d[k];
        active_q[k] <= active_d[k];
      end
    end
  end

  // Per-channel datapath next-state for all three stages.
  always_comb begin
    logic [CIW-1:0]       x;
    logic [AW-1:0]        idx0, idx1;
    logic signed [PW-1:0] d_ext, f_ext, sh, sum;
    x = '0; idx0 = '0; idx1 = '0; d_ext = '0; f_ext = '0; sh = '0; sum = '0;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      // Stage 1: segment lookup.
      x            = i_data[c*CIW +: CIW];
      idx0         = AW'(x[CIW-1:SEG_SFT]);
      idx1         = idx0 + AW'(1);
      s1_y0_d[c]   = lut_view[idx0];
      s1_diff_d[c] = $signed({1'b0, lut_view[idx1]}) - $signed({1'b0, lut_view[idx0]});
      s1_frac_d[c] = x[SEG_SFT-1:0];
      s1_bx_d[c]   = x[CIW-1 -: COW];
      // Stage 2: slope times fraction.
      d_ext        = PW'(s1_diff_q[c]);
      f_ext        = $signed(PW'({1'b0, s1_frac_q[c]}));
      s2_prod_d[c] = d_ext * f_ext;
      s2_y0_d[c]   = s1_y0_q[c];
      s2_bx_d[c]   = s1_bx_q[c];
      // Stage 3: round, add base knot, clip to the output range.
      sh  = (s2_prod_q[c] + RndC) >>> SEG_SFT;
      sum = $signed(PW'(s2_y0_q[c])) + sh;
      if (s2_bp_q)           s3_y_d[c] = s2_bx_q[c];
      else if (sum < 0)      s3_y_d[c] = '0;
      else if (sum > MaxY)   s3_y_d[c] = '1;
      else                   s3_y_d[c] = sum[COW-1:0];
    end
    hstr_d = {hstr_q[1:0], i_hstr};
    href_d = {href_q[1:0], i_href};
    hend_d = {hend_q[1:0], i_hend};
  end

  // Pipeline registers and sync-control delay line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_bp_q <= 1'b0;
      s2_bp_q <= 1'b0;
      hstr_q  <= '0;
      href_q  <= '0;
      hend_q  <= '0;
      for (int unsigned c = 0; c < CH_NUM; c++) begin
        s1_y0_q[c]   <= '0;
        s1_diff_q[c] <= '0;
        s1_frac_q[c] <= '0;
        s1_bx_q[c]   <= '0;
        s2_y0_q[c]   <= '0;
        s2_prod_q[c] <= '0;
        s2_bx_q[c]   <= '0;
        s3_y_q[c]    <= '0;
      end
    end else begin
      s1_bp_q <= i_bypass;
      s2_bp_q <= s1_bp_q;
      hstr_q  <= hstr_d;
      href_q  <= href_d;
      hend_q  <= hend_d;
      for (int unsigned c = 0; c < CH_NUM; c++) begin
        s1_y0_q[c]   <= s1_y0_d[c];
        s1_diff_q[c] <= s1_diff_d[c];
        s1_frac_q[c] <= s1_frac_d[c];
        s1_bx_q[c]   <= s1_bx_d[c];
        s2_y0_q[c]   <= s2_y0_d[c];
        s2_prod_q[c] <= s2_prod_d[c];
        s2_bx_q[c]   <= s2_bx_d[c];
        s3_y_q[c]    <= s3_y_d[c];
      end
    end
  end

  // Output packing.
  always_comb begin
    o_data = '0;
    for (int unsigned c = 0; c < CH_NUM; c++) o_data[c*COW +: COW] = s3_y_q[c];
  end

  assign o_hstr        = hstr_q[2];
  assign o_href        = href_q[2];
  assign o_hend        = hend_q[2];
  assign o_commit_pend = (state_q == StPend);

endmodule
